ripple_borrow_subtractor_seq: RTL

//  Multi-cycle chunked ripple-borrow subtractor: diff = A - B - Bin, CHUNK bits per cycle, LSB chunk first.

---
 rtl/qa_arith_pkg.sv | 27 ++
 rtl/full_subtractor.sv | 14 +
 rtl/ripple_borrow_subtractor_seq.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/qa_arith_pkg.sv
// Shared quaternion-datapath arithmetic definitions: subtractor FSM states,
// sequencer counter sizing and signed saturation limits.
package qa_arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } rbs_state_e;

  // Counter must index WIDTH/CHUNK chunks; keep at least one bit for the single-chunk case.
  function automatic int rbs_cnt_w(input int width, input int chunk);
    int n;
    n = width / chunk;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Signed limits for widths up to 64 bits; callers slice to their own width.
  function automatic logic [63:0] rbs_smax(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] rbs_smin(input int width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, bout set when the bit borrows.
// Pure combinational cell chained to form the per-cycle borrow ripple.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/ripple_borrow_subtractor_seq.sv
// Chunked ripple-borrow subtractor, CHUNK bits per cycle LSB first, one op in flight.
// Optional signed saturation of the result on overflow: define RBS_SATURATE_EN.
module ripple_borrow_subtractor_seq
  import qa_arith_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = rbs_cnt_w(WIDTH, CHUNK);
  localparam logic [CW-1:0] LAST_CNT = CW'(NCHUNK - 1);

  generate
    if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_chunk
      $error("ripple_borrow_subtractor_seq: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

`ifdef RBS_SATURATE_EN
  localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(rbs_smax(WIDTH));
  localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(rbs_smin(WIDTH));
`endif

  rbs_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             brw_q, brw_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  int               chunk_base;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK-1:0] d_chunk;
  logic [CHUNK:0]   brw_chain;
  logic             raw_ovf;

  assign chunk_base = int'(cnt_q) * CHUNK;
  assign a_chunk    = a_q[chunk_base +: CHUNK];
  assign b_chunk    = b_q[chunk_base +: CHUNK];
  assign brw_chain[0] = brw_q;

  generate
    for (genvar gi = 0; gi < CHUNK; gi++) begin : g_fs
      full_subtractor u_fs (
        .a    (a_chunk[gi]),
        .b    (b_chunk[gi]),
        .bin  (brw_chain[gi]),
        .d    (d_chunk[gi]),
        .bout (brw_chain[gi+1])
      );
    end
  endgenerate

  // Only meaningful on the top chunk, where d_chunk's MSB is the raw result MSB.
  assign raw_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (d_chunk[CHUNK-1] != a_q[WIDTH-1]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    brw_d   = brw_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_BUSY;
          a_d     = a;
          b_d     = b;
          brw_d   = bin;
          cnt_d   = '0;
        end
      end
      ST_BUSY: begin
        diff_d[chunk_base +: CHUNK] = d_chunk;
        brw_d = brw_chain[CHUNK];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = ST_DONE;
          cnt_d   = '0;
          bout_d  = brw_chain[CHUNK];
          ovf_d   = raw_ovf;
`ifdef RBS_SATURATE_EN
          if (raw_ovf) begin
            diff_d = a_q[WIDTH-1] ? SAT_MIN : SAT_MAX;
          end
`endif
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      brw_q   <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      brw_q   <= brw_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;

endmodule
